// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle between the multicycle core's two requesters, the arbiter and the
// unified memory port. The arbiter uses the slave view; the core/memory side uses master.
interface riscv_mem_arbiter_if;
    // Instruction-fetch requester
    logic        iReq;
    logic [31:0] iAddr;
    logic [31:0] iRdata;
    logic        iValid;
    // Load/store requester
    logic        dRead;
    logic        dWrite;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [31:0] dRdata;
    logic        dValid;
    // Unified memory port
    logic [31:0] mAddr;
    logic [31:0] mWdata;
    logic        mRead;
    logic        mWrite;
    logic [31:0] mRdata;
    logic        mReady;
    logic        busErr;

    modport slave (
        input  iReq, iAddr, dRead, dWrite, dAddr, dWdata, mRdata, mReady,
        output iRdata, iValid, dRdata, dValid, mAddr, mWdata, mRead, mWrite, busErr
    );

    modport master (
        output iReq, iAddr, dRead, dWrite, dAddr, dWdata, mRdata, mReady,
        input  iRdata, iValid, dRdata, dValid, mAddr, mWdata, mRead, mWrite, busErr
    );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory port between fetch and
// load/store, with registered strobes and a watchdog that turns a hung memory into busErr.
module riscv_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input logic               clk,
    input logic               rst,
    riscv_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state, state_d;
    logic       last_grant;
    logic [7:0] wd_cnt;
    logic       d_req, grant_i, grant_d, done, timeout;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        state_d = state;
        d_req   = bus.dRead | bus.dWrite;
        grant_i = 1'b0;
        grant_d = 1'b0;
        done    = 1'b0;
        timeout = 1'b0;
        case (state)
            IDLE: begin
                // The valid cycle still sees the finished request held, so skip it.
                if (!(bus.iValid | bus.dValid)) begin
                    if (bus.iReq && (!d_req || last_grant)) begin
                        grant_i = 1'b1;
                        state_d = IBUSY;
                    end else if (d_req) begin
                        grant_d = 1'b1;
                        state_d = DBUSY;
                    end
                end
            end
            IBUSY, DBUSY: begin
                if (bus.mReady)            done    = 1'b1;
                else if (wd_cnt == WD_LAST) timeout = 1'b1;
                if (done || timeout) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            wd_cnt     <= 8'd0;
            bus.iRdata <= 32'd0;
            bus.iValid <= 1'b0;
            bus.dRdata <= 32'd0;
            bus.dValid <= 1'b0;
            bus.mAddr  <= 32'd0;
            bus.mWdata <= 32'd0;
            bus.mRead  <= 1'b0;
            bus.mWrite <= 1'b0;
            bus.busErr <= 1'b0;
        end else begin
            bus.iValid <= 1'b0;
            bus.dValid <= 1'b0;

            if (grant_i) begin
                last_grant <= 1'b0;
                wd_cnt     <= 8'd0;
                bus.mAddr  <= bus.iAddr;
                bus.mRead  <= 1'b1;
                bus.mWrite <= 1'b0;
            end
            if (grant_d) begin
                last_grant <= 1'b1;
                wd_cnt     <= 8'd0;
                bus.mAddr  <= bus.dAddr;
                bus.mWdata <= bus.dWdata;
                bus.mRead  <= ~bus.dWrite;
                bus.mWrite <= bus.dWrite;
            end

            if (state != IDLE && !bus.mReady) wd_cnt <= wd_cnt + 8'd1;

            if (done || timeout) begin
                bus.mRead  <= 1'b0;
                bus.mWrite <= 1'b0;
                if (state == IBUSY) bus.iValid <= 1'b1;
                else                bus.dValid <= 1'b1;
            end

            // A store's mRead is low, so its completion leaves dRdata alone.
            if (done) begin
                if (state == IBUSY)  bus.iRdata <= bus.mRdata;
                else if (bus.mRead)  bus.dRdata <= bus.mRdata;
            end

            if (timeout) begin
                bus.busErr <= 1'b1;
                if (state == IBUSY) bus.iRdata <= 32'd0;
                else                bus.dRdata <= 32'd0;
            end
        end
    end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: a transaction-level model checked every cycle,
// plus hand-computed literal expectations at key cycles of each scenario.
module tb_riscv_mem_arbiter;
    localparam int T = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    bit   cmp_en = 1'b0;

    riscv_mem_arbiter_if bus ();

    riscv_mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Model: who owns the memory, how long it has waited, and what each output must read.
    typedef enum {NONE, FETCH, LOAD, STORE} owner_t;
    owner_t      owner = NONE;
    int          waited = 0;
    bit          last_was_data = 1'b1;
    logic [31:0] e_irdata = '0, e_drdata = '0, e_maddr = '0, e_mwdata = '0;
    logic        e_ival = 0, e_dval = 0, e_mread = 0, e_mwrite = 0, e_err = 0;

    task automatic finish_txn(input logic [31:0] data, input bit aborted);
        if (owner == FETCH) begin
            e_ival   = 1'b1;
            e_irdata = data;
        end else begin
            e_dval = 1'b1;
            if (owner == LOAD || aborted) e_drdata = data;
        end
        e_mread  = 1'b0;
        e_mwrite = 1'b0;
        if (aborted) e_err = 1'b1;
        owner = NONE;
    endtask

    task automatic model_step();
        bit had_pulse;
        bit data_req;
        bit pick_fetch;
        if (rst) begin
            owner = NONE; waited = 0; last_was_data = 1'b1;
            e_irdata = '0; e_drdata = '0; e_maddr = '0; e_mwdata = '0;
            e_ival = 0; e_dval = 0; e_mread = 0; e_mwrite = 0; e_err = 0;
            return;
        end
        had_pulse = e_ival | e_dval;
        e_ival    = 1'b0;
        e_dval    = 1'b0;
        data_req  = bus.dRead | bus.dWrite;
        if (owner == NONE) begin
            if (!had_pulse && (bus.iReq || data_req)) begin
                pick_fetch = bus.iReq && (!data_req || last_was_data);
                waited = 0;
                if (pick_fetch) begin
                    owner = FETCH; last_was_data = 1'b0;
                    e_maddr = bus.iAddr; e_mread = 1'b1; e_mwrite = 1'b0;
                end else begin
                    owner = bus.dWrite ? STORE : LOAD; last_was_data = 1'b1;
                    e_maddr = bus.dAddr; e_mwdata = bus.dWdata;
                    e_mread = ~bus.dWrite; e_mwrite = bus.dWrite;
                end
            end
        end else if (bus.mReady) begin
            finish_txn(bus.mRdata, 1'b0);
        end else begin
            waited++;
            if (waited >= T) finish_txn(32'd0, 1'b1);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("iValid", bus.iValid, e_ival);
            check("dValid", bus.dValid, e_dval);
            check("iRdata", bus.iRdata, e_irdata);
            check("dRdata", bus.dRdata, e_drdata);
            check("mAddr",  bus.mAddr,  e_maddr);
            check("mWdata", bus.mWdata, e_mwdata);
            check("mRead",  bus.mRead,  e_mread);
            check("mWrite", bus.mWrite, e_mwrite);
            check("busErr", bus.busErr, e_err);
            check("valid exclusive", bus.iValid & bus.dValid, 1'b0);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.iReq = 0; bus.iAddr = '0; bus.dRead = 0; bus.dWrite = 0;
        bus.dAddr = '0; bus.dWdata = '0; bus.mRdata = '0; bus.mReady = 0;
        tick(); tick();
        cmp_en = 1'b1;
        check("reset mRead",  bus.mRead,  1'b0);
        check("reset mAddr",  bus.mAddr,  32'h0);
        check("reset busErr", bus.busErr, 1'b0);
        check("reset iValid", bus.iValid, 1'b0);
        rst = 1'b0;

        // Zero-wait fetch
        bus.iReq = 1; bus.iAddr = 32'h00400000; bus.mReady = 1; bus.mRdata = 32'h00500093;
        tick();
        check("t1 c1 mRead", bus.mRead, 1'b1);
        check("t1 c1 mAddr", bus.mAddr, 32'h00400000);
        tick();
        check("t1 c2 iValid", bus.iValid, 1'b1);
        check("t1 c2 iRdata", bus.iRdata, 32'h00500093);
        bus.iReq = 0; bus.mReady = 0;
        tick();
        check("t1 c3 iValid", bus.iValid, 1'b0);

        // Simultaneous fetch and load after reset: grants I, D, I
        do_reset();
        bus.iReq = 1; bus.dRead = 1; bus.iAddr = 32'h100; bus.dAddr = 32'h2000;
        bus.mReady = 1; bus.mRdata = 32'h11111111;
        tick();
        check("t2 grant1 mAddr", bus.mAddr, 32'h100);
        tick();
        check("t2 c2 iRdata", bus.iRdata, 32'h11111111);
        bus.mRdata = 32'h22222222;
        tick();
        check("t2 c3 idle mRead", bus.mRead, 1'b0);
        tick();
        check("t2 grant2 mAddr", bus.mAddr, 32'h2000);
        tick();
        check("t2 c5 dValid", bus.dValid, 1'b1);
        check("t2 c5 dRdata", bus.dRdata, 32'h22222222);
        bus.mRdata = 32'h33333333;
        tick();
        tick();
        check("t2 grant3 mAddr", bus.mAddr, 32'h100);
        tick();
        check("t2 c8 iValid", bus.iValid, 1'b1);
        bus.iReq = 0; bus.dRead = 0; bus.mReady = 0;
        tick();

        // Store with three wait cycles
        bus.dWrite = 1; bus.dAddr = 32'h10010000; bus.dWdata = 32'hCAFEF00D;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check("t3 mWrite", bus.mWrite, 1'b1);
            check("t3 mRead",  bus.mRead,  1'b0);
            check("t3 mAddr",  bus.mAddr,  32'h10010000);
            check("t3 mWdata", bus.mWdata, 32'hCAFEF00D);
        end
        bus.mReady = 1; bus.mRdata = 32'hBAD0BAD0;
        tick();
        check("t3 dValid", bus.dValid, 1'b1);
        check("t3 dRdata kept", bus.dRdata, 32'h22222222);
        check("t3 mWrite low", bus.mWrite, 1'b0);
        bus.dWrite = 0; bus.mReady = 0;
        tick();
        check("t3 dValid once", bus.dValid, 1'b0);

        // Hung memory: abort in cycle T+1, then the next request is served
        bus.iReq = 1; bus.iAddr = 32'h40;
        for (int c = 1; c <= T; c++) begin
            tick();
            check("t4 no early valid", bus.iValid, 1'b0);
        end
        tick();
        check("t4 abort iValid", bus.iValid, 1'b1);
        check("t4 abort iRdata", bus.iRdata, 32'h0);
        check("t4 busErr", bus.busErr, 1'b1);
        bus.iReq = 0; bus.dRead = 1; bus.dAddr = 32'h300; bus.mReady = 1; bus.mRdata = 32'h12345678;
        tick();
        tick();
        check("t4 next mAddr", bus.mAddr, 32'h300);
        tick();
        check("t4 next dRdata", bus.dRdata, 32'h12345678);
        check("t4 busErr sticky", bus.busErr, 1'b1);
        bus.dRead = 0; bus.mReady = 0;
        tick();

        // Reset in the second busy cycle
        bus.iReq = 1; bus.iAddr = 32'h500;
        tick();
        check("t5 c1 mRead", bus.mRead, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        check("t5 mRead dropped", bus.mRead, 1'b0);
        check("t5 no valid", bus.iValid, 1'b0);
        check("t5 busErr cleared", bus.busErr, 1'b0);
        rst = 1'b0; bus.iReq = 0;
        tick();
        check("t5 still no valid", bus.iValid, 1'b0);

        // mReady arriving in the last allowed cycle completes normally
        bus.iReq = 1; bus.iAddr = 32'h600; bus.mRdata = 32'h600D600D;
        tick(); tick(); tick(); tick();
        bus.mReady = 1;
        tick();
        check("t6 iValid", bus.iValid, 1'b1);
        check("t6 iRdata", bus.iRdata, 32'h600D600D);
        check("t6 no busErr", bus.busErr, 1'b0);
        bus.iReq = 0; bus.mReady = 0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
